dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/dcache_sram.sv | 56 +++++
 rtl/dcache_controller.sv | 177 +++++++++++++++++
 tb/tb_dcache_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg -- shared types and geometry for the direct-mapped data cache.
//   state_t       controller FSM states
//   memReq_t      backing-memory request bundle (req/write/addr/wdata)
//   LINE_W        line width in bits (8 x 32-bit words)
//   WORD_OFF_W    word-offset field width inside a line
//   indexWidth()  index field width for a given line count
//   tagWidth()    tag field width for a given line count
package dcache_pkg;

   localparam int LINE_W     = 256;
   localparam int WORD_W     = 32;
   localparam int WORD_OFF_W = 3;
   localparam int BYTE_OFF_W = 2;
   localparam int LINE_OFF_W = WORD_OFF_W + BYTE_OFF_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE,
      REFILL
   } state_t;

   typedef struct packed {
      logic              req;
      logic              write;
      logic [31:0]       addr;
      logic [LINE_W-1:0] wdata;
   } memReq_t;

   function automatic int indexWidth(input int numLines);
      return $clog2(numLines);
   endfunction

   function automatic int tagWidth(input int numLines);
      return 32 - LINE_OFF_W - $clog2(numLines);
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram -- tag/valid/dirty/data storage for the direct-mapped cache.
//   clk_i, rst_i          clock; synchronous active-low reset (clears valid/dirty only)
//   rdIdx                 read-port index; rdValid/rdDirty/rdTag/rdLine combinational
//   wrEn, wrIdx, wrTag,
//   wrLine, wrDirty       write port; a write always marks the line valid
// Tag and data arrays are deliberately not reset.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int IDX_W     = 5,
   parameter int TAG_W     = 22,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     rdIdx,
   output logic                 rdValid,
   output logic                 rdDirty,
   output logic [TAG_W-1:0]     rdTag,
   output logic [LINE_BITS-1:0] rdLine,
   input  logic                 wrEn,
   input  logic [IDX_W-1:0]     wrIdx,
   input  logic [TAG_W-1:0]     wrTag,
   input  logic [LINE_BITS-1:0] wrLine,
   input  logic                 wrDirty
);

   logic [NUM_LINES-1:0] validBits;
   logic [NUM_LINES-1:0] dirtyBits;
   logic [TAG_W-1:0]     tagMem  [NUM_LINES];
   logic [LINE_BITS-1:0] dataMem [NUM_LINES];

   assign rdValid = validBits[rdIdx];
   assign rdDirty = dirtyBits[rdIdx];
   assign rdTag   = tagMem[rdIdx];
   assign rdLine  = dataMem[rdIdx];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         validBits <= '0;
         dirtyBits <= '0;
      end else if (wrEn) begin
         validBits[wrIdx] <= 1'b1;
         dirtyBits[wrIdx] <= wrDirty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wrEn) begin
         tagMem[wrIdx]  <= wrTag;
         dataMem[wrIdx] <= wrLine;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller -- write-back, write-allocate direct-mapped data cache
// sitting in the MEM stage of a pipeline.
//   clk_i, rst_i                    clock; synchronous active-low reset
//   cpu_read_i/cpu_write_i/
//   cpu_addr_i/cpu_wdata_i          MEM-stage access (both high = store)
//   cpu_rdata_o                     load data, valid on a read hit
//   mem_stall_o                     freezes the pipeline on a miss
//   mem_req_o/mem_write_o/
//   mem_addr_o/mem_wdata_o          line writeback / fetch request
//   mem_ack_i/mem_rdata_i           one-cycle completion and fetched line
//   hit_cnt_o/miss_cnt_o            statistics counters
// Build option: define DCACHE_STATS_EN to get live counters; otherwise the
// counter ports are tied to zero.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_read_i,
   input  logic                 cpu_write_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_wdata_i,
   output logic [31:0]          cpu_rdata_o,
   output logic                 mem_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic                 mem_ack_i,
   input  logic [LINE_BITS-1:0] mem_rdata_i,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
);

   localparam int IDX_W = indexWidth(NUM_LINES);
   localparam int TAG_W = tagWidth(NUM_LINES);

   // Address fields; the byte offset is dropped (word accesses only).
   logic [WORD_OFF_W-1:0] offset;
   logic [IDX_W-1:0]      idx;
   logic [TAG_W-1:0]      tag;
   logic                  unusedByteOff;

   assign offset        = cpu_addr_i[BYTE_OFF_W +: WORD_OFF_W];
   assign idx           = cpu_addr_i[LINE_OFF_W +: IDX_W];
   assign tag           = cpu_addr_i[31 -: TAG_W];
   assign unusedByteOff = ^cpu_addr_i[BYTE_OFF_W-1:0];

   state_t               state, stateNext;
   memReq_t              memReq;
   logic [LINE_BITS-1:0] fillBuf;

   logic                 rdValid, rdDirty;
   logic [TAG_W-1:0]     rdTag;
   logic [LINE_BITS-1:0] rdLine;
   logic                 wrEn, wrDirty;
   logic [LINE_BITS-1:0] wrLine, mergedLine;

   logic cpuReq, isStore, tagMatch, hit, missStart;

   assign cpuReq    = cpu_read_i | cpu_write_i;
   assign isStore   = cpu_write_i;
   assign tagMatch  = rdValid && (rdTag == tag);
   // Inputs stay frozen while stalled, so after refill the same access
   // re-evaluates in IDLE and completes as an ordinary hit.
   assign hit       = rst_i && (state == IDLE) && cpuReq && tagMatch;
   assign missStart = rst_i && (state == IDLE) && cpuReq && !tagMatch;

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W),
      .LINE_BITS (LINE_BITS)
   ) uSram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .rdIdx   (idx),
      .rdValid (rdValid),
      .rdDirty (rdDirty),
      .rdTag   (rdTag),
      .rdLine  (rdLine),
      .wrEn    (wrEn),
      .wrIdx   (idx),
      .wrTag   (tag),
      .wrLine  (wrLine),
      .wrDirty (wrDirty)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= stateNext;
   end

   always_ff @(posedge clk_i) begin
      if (state == ALLOCATE && mem_ack_i) fillBuf <= mem_rdata_i;
   end

   // Request fields come straight from the frozen CPU address and the
   // untouched victim entry, so they hold steady until the ack.
   always_comb begin
      stateNext = state;
      memReq    = '0;
      case (state)
         IDLE: begin
            if (missStart) stateNext = (rdValid && rdDirty) ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            memReq.req   = 1'b1;
            memReq.write = 1'b1;
            memReq.addr  = {rdTag, idx, {LINE_OFF_W{1'b0}}};
            memReq.wdata = rdLine;
            if (mem_ack_i) stateNext = ALLOCATE;
         end
         ALLOCATE: begin
            memReq.req  = 1'b1;
            memReq.addr = {tag, idx, {LINE_OFF_W{1'b0}}};
            if (mem_ack_i) stateNext = REFILL;
         end
         REFILL: begin
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (!rst_i) memReq = '0;
   end

   assign mem_req_o   = memReq.req;
   assign mem_write_o = memReq.write;
   assign mem_addr_o  = memReq.addr;
   assign mem_wdata_o = memReq.wdata;

   always_comb begin
      mergedLine = rdLine;
      mergedLine[offset*WORD_W +: WORD_W] = cpu_wdata_i;
   end

   // Single write port: refill installs a clean line, a store hit rewrites
   // the line with one word replaced and marks it dirty.
   assign wrEn    = rst_i && ((state == REFILL) || (hit && isStore));
   assign wrLine  = (state == REFILL) ? fillBuf : mergedLine;
   assign wrDirty = (state != REFILL);

   assign cpu_rdata_o = hit ? rdLine[offset*WORD_W +: WORD_W] : '0;
   assign mem_stall_o = rst_i && ((state != IDLE) || (cpuReq && !tagMatch));

`ifdef DCACHE_STATS_EN
   logic [31:0] hitCnt, missCnt;
   logic        replay;  // set between a miss and its replayed hit

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         hitCnt  <= '0;
         missCnt <= '0;
         replay  <= 1'b0;
      end else begin
         if (missStart) begin
            missCnt <= missCnt + 32'd1;
            replay  <= 1'b1;
         end
         if (hit) begin
            if (!replay) hitCnt <= hitCnt + 32'd1;
            replay <= 1'b0;
         end
      end
   end

   assign hit_cnt_o  = hitCnt;
   assign miss_cnt_o = missCnt;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller -- directed scoreboard bench for dcache_controller.
// Stimulus pushes expected CPU completions and memory requests into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_dcache_controller;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_read_i, cpu_write_i;
   logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
   logic         mem_stall_o, mem_req_o, mem_write_o, mem_ack_i;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o, mem_rdata_i;
   logic [31:0]  hit_cnt_o, miss_cnt_o;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        chkData;
      logic [31:0] rdata;
   } cpuExp_t;

   typedef struct packed {
      logic         write;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } memExp_t;

   cpuExp_t cpuQ[$];
   memExp_t memQ[$];

   dcache_controller #(.NUM_LINES(32), .LINE_BITS(256)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cpu_read_i  (cpu_read_i),
      .cpu_write_i (cpu_write_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .mem_stall_o (mem_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_write_o (mem_write_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, got, exp);
      end
   endtask

   task automatic checkLine(input string nm, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, got, exp);
      end
   endtask

   task automatic checkCnt(input int expHit, input int expMiss);
`ifdef DCACHE_STATS_EN
      check32("hit_cnt", hit_cnt_o, expHit);
      check32("miss_cnt", miss_cnt_o, expMiss);
`else
      if (expHit >= 0 && expMiss >= 0) begin
         check32("hit_cnt_tied", hit_cnt_o, 32'd0);
         check32("miss_cnt_tied", miss_cnt_o, 32'd0);
      end
`endif
   endtask

   function automatic logic [255:0] mkLine(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
      return l;
   endfunction

   task automatic pushCpu(input logic chk, input logic [31:0] d);
      cpuExp_t e;
      e.chkData = chk;
      e.rdata   = d;
      cpuQ.push_back(e);
   endtask

   task automatic pushMem(input logic w, input logic [31:0] a, input logic [255:0] d);
      memExp_t e;
      e.write = w;
      e.addr  = a;
      e.wdata = d;
      memQ.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic         reqPrev = 1'b0, ackPrev = 1'b0;
   logic [31:0]  addrPrev = '0;
   logic [255:0] wdataPrev = '0;
   cpuExp_t      mc;
   memExp_t      mm;

   always @(negedge clk_i) begin
      if (rst_i === 1'b1) begin
         if ((cpu_read_i || cpu_write_i) && !mem_stall_o) begin
            if (cpuQ.size() == 0) begin
               checks++; errors++;
               $display("FAIL cpu_unexpected: got completion at %h, want none", cpu_addr_i);
            end else begin
               mc = cpuQ.pop_front();
               if (mc.chkData) check32("cpu_rdata", cpu_rdata_o, mc.rdata);
            end
         end
         if (mem_req_o && (!reqPrev || ackPrev)) begin
            if (memQ.size() == 0) begin
               checks++; errors++;
               $display("FAIL mem_unexpected: got request at %h, want none", mem_addr_o);
            end else begin
               mm = memQ.pop_front();
               check32("mem_write", {31'd0, mem_write_o}, {31'd0, mm.write});
               check32("mem_addr", mem_addr_o, mm.addr);
               if (mm.write) checkLine("mem_wdata", mem_wdata_o, mm.wdata);
            end
         end else if (mem_req_o && reqPrev && !ackPrev) begin
            check32("mem_addr_hold", mem_addr_o, addrPrev);
            checkLine("mem_wdata_hold", mem_wdata_o, wdataPrev);
         end
         reqPrev   = mem_req_o;
         ackPrev   = mem_ack_i;
         addrPrev  = mem_addr_o;
         wdataPrev = mem_wdata_o;
      end else begin
         reqPrev = 1'b0;
         ackPrev = 1'b0;
      end
   end

   // Drives one access from posedge+1 until it completes, acting as the
   // backing memory (ack after ackDelay waiting cycles per request).
   task automatic doAccess(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ackDelay,
                           input logic [255:0] line, input logic expMiss, input int expAcks);
      int  waitN  = 0;
      int  ackIt  = -100;
      int  acks   = 0;
      bit  done   = 0;
      cpu_read_i  = rd;
      cpu_write_i = wr;
      cpu_addr_i  = addr;
      cpu_wdata_i = wdata;
      for (int it = 0; it < 300 && !done; it++) begin
         #1;
         if (it == 0) check32("stall_on_request", {31'd0, mem_stall_o}, {31'd0, expMiss});
         if (!mem_stall_o) begin
            done = 1;
            if (expMiss) check32("ack_to_release", it - ackIt, 32'd2);
            check32("ack_count", acks, expAcks);
         end else if (mem_req_o) begin
            if (waitN == ackDelay) begin
               mem_ack_i   = 1'b1;
               mem_rdata_i = line;
               waitN       = 0;
               ackIt       = it;
               acks++;
            end else begin
               waitN++;
            end
         end
         @(posedge clk_i);
         #1;
         mem_ack_i = 1'b0;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL access_timeout: got no completion at %h, want completion", addr);
      end
      cpu_read_i  = 1'b0;
      cpu_write_i = 1'b0;
   endtask

   logic [255:0] l1, l1wb, l2, l3, l4, l4wb, l5;
   bit           seen;

   initial begin
      l1 = mkLine(32'hA000_0000); l1[31:0] = 32'hDEAD_BEEF;
      l1wb = l1; l1wb[63:32] = 32'h1234_5678;
      l2 = mkLine(32'hB000_0000);
      l3 = mkLine(32'hC000_0000);
      l4 = mkLine(32'hD000_0000);
      l4wb = l4; l4wb[31:0] = 32'hCAFE_F00D;
      l5 = mkLine(32'hE000_0000);

      rst_i = 1'b0; cpu_read_i = 1'b1; cpu_write_i = 1'b0;
      cpu_addr_i = 32'h40; cpu_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check32("rst_stall", {31'd0, mem_stall_o}, 32'd0);
      check32("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check32("rst_mem_write", {31'd0, mem_write_o}, 32'd0);
      check32("rst_mem_addr", mem_addr_o, 32'd0);
      checkLine("rst_mem_wdata", mem_wdata_o, 256'd0);
      check32("rst_rdata", cpu_rdata_o, 32'd0);
      check32("rst_hit_cnt", hit_cnt_o, 32'd0);
      check32("rst_miss_cnt", miss_cnt_o, 32'd0);
      cpu_read_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      // cold read miss then read data from the refilled line
      pushMem(1'b0, 32'h40, '0); pushCpu(1'b1, 32'hDEAD_BEEF);
      doAccess(1, 0, 32'h40, 0, 2, l1, 1, 1);
      checkCnt(0, 1);

      // write hit, then read back
      pushCpu(1'b0, '0);
      doAccess(0, 1, 32'h44, 32'h1234_5678, 0, '0, 0, 0);
      checkCnt(1, 1);
      pushCpu(1'b1, 32'h1234_5678);
      doAccess(1, 0, 32'h44, 0, 0, '0, 0, 0);
      checkCnt(2, 1);

      // conflict miss on dirty line, slow memory
      pushMem(1'b1, 32'h40, l1wb); pushMem(1'b0, 32'h440, '0); pushCpu(1'b1, 32'hB000_0000);
      doAccess(1, 0, 32'h440, 0, 10, l2, 1, 2);
      checkCnt(2, 2);

      // reset during ALLOCATE; late ack must be ignored
      pushMem(1'b0, 32'h40, '0);
      cpu_read_i = 1'b1; cpu_addr_i = 32'h40;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         #1;
         if (mem_req_o) seen = 1;
         @(posedge clk_i); #1;
      end
      check32("alloc_reached", {31'd0, seen}, 32'd1);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      check32("midrst_stall", {31'd0, mem_stall_o}, 32'd0);
      check32("midrst_mem_req", {31'd0, mem_req_o}, 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1; cpu_read_i = 1'b0;
      #1;
      check32("postrst_mem_req", {31'd0, mem_req_o}, 32'd0);
      mem_ack_i = 1'b1; mem_rdata_i = l1;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      #1;
      check32("late_ack_mem_req", {31'd0, mem_req_o}, 32'd0);
      check32("late_ack_stall", {31'd0, mem_stall_o}, 32'd0);
      checkCnt(0, 0);
      @(posedge clk_i); #1;
      pushMem(1'b0, 32'h40, '0); pushCpu(1'b1, 32'hC000_0000);
      doAccess(1, 0, 32'h40, 0, 1, l3, 1, 1);
      checkCnt(0, 1);

      // read+write both high on a miss: fetch, then store hit marks dirty
      pushMem(1'b0, 32'h80, '0); pushCpu(1'b0, '0);
      doAccess(1, 1, 32'h80, 32'hCAFE_F00D, 0, l4, 1, 1);
      checkCnt(0, 2);
      pushCpu(1'b1, 32'hCAFE_F00D);
      doAccess(1, 0, 32'h80, 0, 0, '0, 0, 0);
      pushCpu(1'b1, 32'hD000_0001);
      doAccess(1, 0, 32'h84, 0, 0, '0, 0, 0);
      checkCnt(2, 2);
      pushMem(1'b1, 32'h80, l4wb); pushMem(1'b0, 32'h480, '0); pushCpu(1'b1, 32'hE000_0000);
      doAccess(1, 0, 32'h480, 0, 3, l5, 1, 2);
      checkCnt(2, 3);

      repeat (2) @(posedge clk_i);
      check32("cpu_queue_empty", cpuQ.size(), 32'd0);
      check32("mem_queue_empty", memQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
